// File: rtl/imm_extend_pipe.sv
// Two-stage elastic immediate extender: S1 holds the raw request, S2 the decoded result.
// Define IMM_EXTEND_IW_EN to enable the IW (wide-move) format on Ctrl=100.
`timescale 1ns/1ps
module imm_extend_pipe #(
  parameter int DATA_W    = 64,
  parameter int ERR_CNT_W = 8
) (
  input  logic                 CLK,
  input  logic                 resetl,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [31:0]          Instr,
  input  logic [2:0]           Ctrl,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [DATA_W-1:0]    BusImm,
  output logic                 err,
  output logic [ERR_CNT_W-1:0] err_cnt
);

  logic              s1_v;
  logic [25:0]       s1_instr;
  logic [2:0]        s1_ctrl;
  logic              s2_v;
  logic [DATA_W-1:0] s2_imm;
  logic              s2_err;
  logic              accept;
  logic              s2_load;
  logic              deliver;
  logic [63:0]       dec_imm;
  logic              dec_err;

  // No format reads above bit 25, so only those bits are stored.
  logic unused_instr;
  assign unused_instr = ^Instr[31:26];

  assign in_ready = !s1_v || !s2_v || out_ready;
  assign accept   = in_valid && in_ready;
  assign s2_load  = s1_v && (!s2_v || out_ready);
  assign deliver  = s2_v && out_ready;

  always_comb begin
    dec_imm = '0;
    dec_err = 1'b0;
    case (s1_ctrl)
      3'b000:  dec_imm = {{52{s1_instr[21]}}, s1_instr[21:10]};
      3'b001:  dec_imm = {{55{s1_instr[20]}}, s1_instr[20:12]};
      3'b010:  dec_imm = {{38{s1_instr[25]}}, s1_instr[25:0]};
      3'b011:  dec_imm = {{45{s1_instr[23]}}, s1_instr[23:5]};
`ifdef IMM_EXTEND_IW_EN
      3'b100: begin
        // A 32-bit result cannot hold halfword positions 2 and 3.
        if ((DATA_W == 32) && s1_instr[22])
          dec_err = 1'b1;
        else
          dec_imm = {48'd0, s1_instr[20:5]} << {s1_instr[22:21], 4'b0000};
      end
`endif
      default: dec_err = 1'b1;
    endcase
  end

  generate
    if (DATA_W < 64) begin : g_narrow
      logic unused_hi;
      assign unused_hi = ^dec_imm[63:DATA_W];
    end
  endgenerate

  always_ff @(posedge CLK or negedge resetl) begin
    if (!resetl) begin
      s1_v     <= 1'b0;
      s1_instr <= '0;
      s1_ctrl  <= '0;
      s2_v     <= 1'b0;
      s2_imm   <= '0;
      s2_err   <= 1'b0;
      err_cnt  <= '0;
    end else begin
      if (accept) begin
        s1_v     <= 1'b1;
        s1_instr <= Instr[25:0];
        s1_ctrl  <= Ctrl;
      end else if (s2_load) begin
        s1_v <= 1'b0;
      end

      if (s2_load) begin
        s2_v   <= 1'b1;
        s2_imm <= dec_imm[DATA_W-1:0];
        s2_err <= dec_err;
      end else if (deliver) begin
        s2_v <= 1'b0;
      end

      if (deliver && s2_err && (err_cnt != {ERR_CNT_W{1'b1}}))
        err_cnt <= err_cnt + ERR_CNT_W'(1);
    end
  end

  assign out_valid = s2_v;
  assign BusImm    = s2_imm;
  assign err       = s2_err;

endmodule
